// File: rtl/rx_rst_sequencer_pkg.sv
// Shared types for the receiver reset sequencer: FSM states, reset cause codes
// and the cause priority encoder.
package rx_rst_sequencer_pkg;

  localparam int TIMER_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_DC   = 2'd1,
    CAUSE_LEN  = 2'd2,
    CAUSE_SW   = 2'd3
  } cause_e;

  // Software beats the length trip, which beats the DC trip.
  function automatic cause_e pick_cause(input logic sw, input logic len, input logic dc);
    cause_e c;
    if (sw) begin
      c = CAUSE_SW;
    end else if (len) begin
      c = CAUSE_LEN;
    end else if (dc) begin
      c = CAUSE_DC;
    end else begin
      c = CAUSE_NONE;
    end
    return c;
  endfunction

endpackage

// File: rtl/rx_rst_sequencer_if.sv
// Request/status bundle between the receiver trip logic and the reset sequencer.
interface rx_rst_sequencer_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 enable;
  logic                 req_dc;
  logic                 req_len;
  logic                 sw_rst_req;
  logic                 clr_cnt;
  logic                 rx_rst;
  logic                 busy;
  logic [1:0]           last_cause;
  logic [CNT_WIDTH-1:0] dc_trip_cnt;
  logic [CNT_WIDTH-1:0] len_trip_cnt;
  logic [CNT_WIDTH-1:0] sw_trip_cnt;
  logic [CNT_WIDTH-1:0] suppressed_cnt;

  modport master (
    output enable, req_dc, req_len, sw_rst_req, clr_cnt,
    input  rx_rst, busy, last_cause,
    input  dc_trip_cnt, len_trip_cnt, sw_trip_cnt, suppressed_cnt
  );

  modport slave (
    input  enable, req_dc, req_len, sw_rst_req, clr_cnt,
    output rx_rst, busy, last_cause,
    output dc_trip_cnt, len_trip_cnt, sw_trip_cnt, suppressed_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear takes precedence
// over a coincident increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_r;

  // Count register: reset/clear to zero, otherwise increment until all-ones.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/rx_rst_sequencer.sv
// Receiver reset sequencer: turns DC/length trips and software requests into a
// fixed-length rx_rst pulse followed by a holdoff window, with event counters.
module rx_rst_sequencer
  import rx_rst_sequencer_pkg::*;
#(
  parameter int RST_LEN     = 8,
  parameter int HOLDOFF_LEN = 64,
  parameter int CNT_WIDTH   = 16
) (
  input logic                clk,
  input logic                rstn,
  rx_rst_sequencer_if.slave  sif
);
  localparam logic [TIMER_WIDTH-1:0] RST_LOAD     = TIMER_WIDTH'(RST_LEN - 1);
  localparam logic [TIMER_WIDTH-1:0] HOLDOFF_LOAD = TIMER_WIDTH'(HOLDOFF_LEN - 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_ONE    = TIMER_WIDTH'(1);
  localparam logic                   HAS_HOLDOFF  = (HOLDOFF_LEN > 0);

  state_e                 state_r;
  logic [TIMER_WIDTH-1:0] timer_r;
  logic                   rx_rst_r;
  logic                   busy_r;
  cause_e                 last_cause_r;

  logic   hw_dc_s;
  logic   hw_len_s;
  logic   hw_req_s;
  logic   timer_zero_s;
  logic   accept_s;
  logic   suppress_s;
  cause_e cause_s;
  logic   inc_dc_s;
  logic   inc_len_s;
  logic   inc_sw_s;

  assign hw_dc_s      = sif.enable & sif.req_dc;
  assign hw_len_s     = sif.enable & sif.req_len;
  assign hw_req_s     = hw_dc_s | hw_len_s;
  assign timer_zero_s = (timer_r == '0);
  assign cause_s      = pick_cause(sif.sw_rst_req, hw_len_s, hw_dc_s);

  // Acceptance and suppression decode. The last holdoff cycle is not counted
  // as suppressed: a request still present there is taken on the next edge.
  always_comb begin
    accept_s   = 1'b0;
    suppress_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        accept_s = hw_req_s | sif.sw_rst_req;
      end
      ST_ASSERT: begin
        suppress_s = hw_req_s & ~sif.sw_rst_req;
      end
      ST_HOLDOFF: begin
        accept_s   = sif.sw_rst_req;
        suppress_s = hw_req_s & ~sif.sw_rst_req & ~timer_zero_s;
      end
      default: begin
        accept_s   = 1'b0;
        suppress_s = 1'b0;
      end
    endcase
  end

  assign inc_dc_s  = accept_s & (cause_s == CAUSE_DC);
  assign inc_len_s = accept_s & (cause_s == CAUSE_LEN);
  assign inc_sw_s  = accept_s & (cause_s == CAUSE_SW);

  // Sequencer FSM with one shared down-timer and registered rx_rst/busy/cause.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r      <= ST_IDLE;
      timer_r      <= '0;
      rx_rst_r     <= 1'b0;
      busy_r       <= 1'b0;
      last_cause_r <= CAUSE_NONE;
    end else if (accept_s) begin
      state_r      <= ST_ASSERT;
      timer_r      <= RST_LOAD;
      rx_rst_r     <= 1'b1;
      busy_r       <= 1'b1;
      last_cause_r <= cause_s;
    end else begin
      case (state_r)
        ST_IDLE: begin
          timer_r  <= '0;
          rx_rst_r <= 1'b0;
          busy_r   <= 1'b0;
        end
        ST_ASSERT: begin
          if (timer_zero_s) begin
            rx_rst_r <= 1'b0;
            if (HAS_HOLDOFF) begin
              state_r <= ST_HOLDOFF;
              timer_r <= HOLDOFF_LOAD;
              busy_r  <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
              timer_r <= '0;
              busy_r  <= 1'b0;
            end
          end else begin
            timer_r <= timer_r - TIMER_ONE;
          end
        end
        ST_HOLDOFF: begin
          if (timer_zero_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            timer_r <= timer_r - TIMER_ONE;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          timer_r  <= '0;
          rx_rst_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign sif.rx_rst     = rx_rst_r;
  assign sif.busy       = busy_r;
  assign sif.last_cause = last_cause_r;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_dc_cnt (
    .clk(clk), .rstn(rstn), .inc(inc_dc_s), .clr(sif.clr_cnt), .count(sif.dc_trip_cnt)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_len_cnt (
    .clk(clk), .rstn(rstn), .inc(inc_len_s), .clr(sif.clr_cnt), .count(sif.len_trip_cnt)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_sw_cnt (
    .clk(clk), .rstn(rstn), .inc(inc_sw_s), .clr(sif.clr_cnt), .count(sif.sw_trip_cnt)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_sup_cnt (
    .clk(clk), .rstn(rstn), .inc(suppress_s), .clr(sif.clr_cnt), .count(sif.suppressed_cnt)
  );

endmodule

// File: tb/tb_rx_rst_sequencer.sv
// Directed bench: default-parameter sequencer plus a short-pulse, no-holdoff,
// 2-bit-counter instance for saturation and clear-priority cases.
module tb_rx_rst_sequencer;
  logic clk;
  logic rstn;
  int   err_cnt = 0;
  int   chk_cnt = 0;
  int   hi_cnt;

  rx_rst_sequencer_if #(.CNT_WIDTH(16)) if1 ();
  rx_rst_sequencer_if #(.CNT_WIDTH(2))  if2 ();

  rx_rst_sequencer #(.RST_LEN(8), .HOLDOFF_LEN(64), .CNT_WIDTH(16)) dut1 (
    .clk(clk), .rstn(rstn), .sif(if1)
  );
  rx_rst_sequencer #(.RST_LEN(3), .HOLDOFF_LEN(0), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rstn(rstn), .sif(if2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  initial begin
    rstn = 1'b0;
    if1.enable = 1'b1; if1.req_dc = 1'b0; if1.req_len = 1'b0; if1.sw_rst_req = 1'b0; if1.clr_cnt = 1'b0;
    if2.enable = 1'b1; if2.req_dc = 1'b0; if2.req_len = 1'b0; if2.sw_rst_req = 1'b0; if2.clr_cnt = 1'b0;
    tick(3);
    rstn = 1'b1;
    tick(1);

    check_val("rst_rx_rst", 32'(if1.rx_rst), 32'd0);
    check_val("rst_busy", 32'(if1.busy), 32'd0);
    check_val("rst_cause", 32'(if1.last_cause), 32'd0);
    check_val("rst_cnts", 32'(if1.dc_trip_cnt | if1.len_trip_cnt | if1.sw_trip_cnt | if1.suppressed_cnt), 32'd0);
    check_val("rst2_busy", 32'(if2.busy), 32'd0);

    // Single DC pulse: 8 cycles of rx_rst, idle again 72 edges after accept.
    if1.req_dc = 1'b1;
    tick(1);
    if1.req_dc = 1'b0;
    check_val("t1_rx_rst_k1", 32'(if1.rx_rst), 32'd1);
    check_val("t1_cause", 32'(if1.last_cause), 32'd1);
    check_val("t1_dc_cnt", 32'(if1.dc_trip_cnt), 32'd1);
    hi_cnt = 1;
    for (int i = 1; i <= 71; i++) begin
      tick(1);
      if (if1.rx_rst) hi_cnt++;
    end
    check_val("t1_busy_k72", 32'(if1.busy), 32'd1);
    tick(1);
    check_val("t1_rx_rst_len", 32'(hi_cnt), 32'd8);
    check_val("t1_busy_k73", 32'(if1.busy), 32'd0);
    check_val("t1_supp", 32'(if1.suppressed_cnt), 32'd0);

    // All three causes together: software wins.
    if1.req_dc = 1'b1; if1.req_len = 1'b1; if1.sw_rst_req = 1'b1;
    tick(1);
    if1.req_dc = 1'b0; if1.req_len = 1'b0; if1.sw_rst_req = 1'b0;
    check_val("t2_cause", 32'(if1.last_cause), 32'd3);
    check_val("t2_sw_cnt", 32'(if1.sw_trip_cnt), 32'd1);
    check_val("t2_dc_cnt", 32'(if1.dc_trip_cnt), 32'd1);
    check_val("t2_len_cnt", 32'(if1.len_trip_cnt), 32'd0);
    tick(72);
    check_val("t2_idle", 32'(if1.busy), 32'd0);

    // Held length request: suppressed through assert+holdoff, retriggers at k+73.
    if1.req_len = 1'b1;
    tick(1);
    check_val("t3_rx_rst", 32'(if1.rx_rst), 32'd1);
    check_val("t3_cause", 32'(if1.last_cause), 32'd2);
    tick(72);
    check_val("t3_busy_k72", 32'(if1.busy), 32'd0);
    check_val("t3_supp", 32'(if1.suppressed_cnt), 32'd71);
    tick(1);
    if1.req_len = 1'b0;
    check_val("t3_retrig", 32'(if1.rx_rst), 32'd1);
    check_val("t3_len_cnt", 32'(if1.len_trip_cnt), 32'd2);
    tick(72);
    check_val("t3_supp_end", 32'(if1.suppressed_cnt), 32'd71);
    check_val("t3_idle", 32'(if1.busy), 32'd0);

    // SW ignored in ASSERT; SW in HOLDOFF (with enable low) restarts full pulse.
    if1.req_dc = 1'b1;
    tick(1);
    if1.req_dc = 1'b0;
    tick(3);
    if1.sw_rst_req = 1'b1;
    tick(1);
    if1.sw_rst_req = 1'b0;
    check_val("t4_sw_in_assert", 32'(if1.sw_trip_cnt), 32'd1);
    check_val("t4_cause_dc", 32'(if1.last_cause), 32'd1);
    if1.enable = 1'b0;
    tick(14);
    check_val("t4_in_holdoff", 32'(if1.rx_rst), 32'd0);
    if1.sw_rst_req = 1'b1;
    tick(1);
    if1.sw_rst_req = 1'b0;
    check_val("t4_restart", 32'(if1.rx_rst), 32'd1);
    check_val("t4_cause_sw", 32'(if1.last_cause), 32'd3);
    check_val("t4_sw_cnt", 32'(if1.sw_trip_cnt), 32'd2);
    hi_cnt = 1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (if1.rx_rst) hi_cnt++;
    end
    check_val("t4_rx_rst_len", 32'(hi_cnt), 32'd8);
    tick(52);
    check_val("t4_idle", 32'(if1.busy), 32'd0);

    // Gating: enable low blocks a DC request entirely.
    if1.req_dc = 1'b1;
    tick(5);
    check_val("t5_busy", 32'(if1.busy), 32'd0);
    check_val("t5_dc_cnt", 32'(if1.dc_trip_cnt), 32'd2);
    check_val("t5_supp", 32'(if1.suppressed_cnt), 32'd71);
    if1.req_dc = 1'b0;
    if1.enable = 1'b1;

    // Counter clear leaves the cause alone.
    if1.clr_cnt = 1'b1;
    tick(1);
    if1.clr_cnt = 1'b0;
    check_val("t6_clr", 32'(if1.dc_trip_cnt | if1.len_trip_cnt | if1.sw_trip_cnt | if1.suppressed_cnt), 32'd0);
    check_val("t6_cause", 32'(if1.last_cause), 32'd3);

    // Reset mid-ASSERT drops everything on the next edge, no residual holdoff.
    if1.req_dc = 1'b1;
    tick(1);
    if1.req_dc = 1'b0;
    check_val("t7_dc_cnt", 32'(if1.dc_trip_cnt), 32'd1);
    tick(2);
    rstn = 1'b0;
    tick(1);
    check_val("t7_rx_rst", 32'(if1.rx_rst), 32'd0);
    check_val("t7_busy", 32'(if1.busy), 32'd0);
    check_val("t7_cause", 32'(if1.last_cause), 32'd0);
    check_val("t7_dc_cnt0", 32'(if1.dc_trip_cnt), 32'd0);
    rstn = 1'b1;
    tick(2);
    check_val("t7_no_holdoff", 32'(if1.busy), 32'd0);

    // Short instance: 3-cycle pulse, no holdoff, 2-bit counters saturate.
    if2.req_dc = 1'b1;
    tick(1);
    if2.req_dc = 1'b0;
    check_val("t8_rx_rst", 32'(if2.rx_rst), 32'd1);
    tick(2);
    check_val("t8_rx_rst_k3", 32'(if2.rx_rst), 32'd1);
    tick(1);
    check_val("t8_rx_rst_off", 32'(if2.rx_rst), 32'd0);
    check_val("t8_busy_off", 32'(if2.busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      if2.req_dc = 1'b1;
      tick(1);
      if2.req_dc = 1'b0;
      tick(3);
    end
    check_val("t8_dc_sat", 32'(if2.dc_trip_cnt), 32'd3);
    check_val("t8_supp", 32'(if2.suppressed_cnt), 32'd0);

    // Clear coincident with an accept: count reads 0, pulse still issued.
    if2.req_dc = 1'b1;
    if2.clr_cnt = 1'b1;
    tick(1);
    if2.clr_cnt = 1'b0;
    check_val("t9_clr_win", 32'(if2.dc_trip_cnt), 32'd0);
    check_val("t9_rx_rst", 32'(if2.rx_rst), 32'd1);
    tick(12);
    check_val("t9_dc_cnt", 32'(if2.dc_trip_cnt), 32'd3);
    check_val("t9_supp_sat", 32'(if2.suppressed_cnt), 32'd3);
    if2.req_dc = 1'b0;
    tick(4);
    check_val("t9_idle", 32'(if2.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
